// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame slave.
//   spi_state_e    : frame FSM states
//   SPI_WR_CMD/RD  : default command codes
//   sample_on_rise : mode helper, 1 when data is sampled on rising SCK
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } spi_state_e;

  localparam logic [7:0] SPI_WR_CMD = 8'hB5;
  localparam logic [7:0] SPI_RD_CMD = 8'h0B;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Pin synchroniser and edge detector for the SPI slave.
//   clk, rst_n  : system clock, async active-low reset
//   sck/cs_n/mosi : raw asynchronous SPI pins
//   cs_n_s, mosi_s : synchronised chip select and data
//   sample_edge/shift_edge : one-cycle SCK edge pulses, only while cs_n_s is low
//   cs_fall/cs_rise : one-cycle chip-select edge pulses
module spi_pin_sync
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic CPOL        = 1'b0,
  parameter logic CPHA        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sample_edge,
  output logic shift_edge,
  output logic cs_fall,
  output logic cs_rise
);

  localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;
  logic                   sck_rise;
  logic                   sck_fall;

  // Synchroniser chains preset to the idle bus state so reset never
  // looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sr  <= {SYNC_STAGES{CPOL}};
      cs_sr   <= '1;
      mosi_sr <= '0;
      sck_d   <= CPOL;
      cs_d    <= 1'b1;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sck_d   <= sck_sr[SYNC_STAGES-1];
      cs_d    <= cs_sr[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sr[SYNC_STAGES-1];
  assign cs_n_s   = cs_sr[SYNC_STAGES-1];
  assign mosi_s   = mosi_sr[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  assign sample_edge = (SAMPLE_RISE ? sck_rise : sck_fall) & ~cs_n_s;
  assign shift_edge  = (SAMPLE_RISE ? sck_fall : sck_rise) & ~cs_n_s;
  assign cs_fall     = cs_d & ~cs_n_s;
  assign cs_rise     = ~cs_d & cs_n_s;

endmodule

// File: rtl/spi_slave_frame.sv
// SPI command/address/data frame slave running on the system clock.
//   clk, rst_n          : system clock, async active-low reset
//   sck, cs_n, mosi     : SPI pins (asynchronous)
//   miso, miso_oe       : SPI read data and its output enable
//   cmd/address/data    : fields of the last completed frame
//   frame_valid, wr_en  : one-cycle completion strobes
//   rd_req, rd_data     : read request and returned data (next cycle)
// Build option: define SPI_SLAVE_READBACK_EN to enable read commands and
// MISO shifting; otherwise rd_req/miso are 0 and read frames complete as
// ordinary frames.
module spi_slave_frame
  import spi_pkg::*;
#(
  parameter int               CMD_W       = 8,
  parameter int               ADDR_W      = 24,
  parameter int               DATA_W      = 32,
  parameter logic             CPOL        = 1'b0,
  parameter logic             CPHA        = 1'b0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [CMD_W-1:0] WR_CMD      = CMD_W'(SPI_WR_CMD),
  parameter logic [CMD_W-1:0] RD_CMD      = CMD_W'(SPI_RD_CMD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [CMD_W-1:0]  cmd,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              frame_valid,
  output logic              wr_en,
  output logic              rd_req,
  input  logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = $clog2(CMD_W + ADDR_W + DATA_W + 1);
  localparam logic [CNT_W-1:0] CMD_END  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(CMD_W + ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_END = CNT_W'(CMD_W + ADDR_W + DATA_W - 1);

  logic cs_n_s, mosi_s, sample_edge, shift_edge, cs_fall, cs_rise;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .CPOL       (CPOL),
    .CPHA       (CPHA)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .cs_n_s     (cs_n_s),
    .mosi_s     (mosi_s),
    .sample_edge(sample_edge),
    .shift_edge (shift_edge),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise)
  );

  spi_state_e        state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CMD_W-1:0]  cmd_sh;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;
  logic              take_bit, last_addr, last_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    take_bit  = 1'b0;
    last_addr = 1'b0;
    last_data = 1'b0;
    case (state)
      ST_IDLE: if (cs_fall) state_nx = ST_CMD;
      ST_CMD: begin
        take_bit = sample_edge;
        if (sample_edge && cnt == CMD_END) state_nx = ST_ADDR;
      end
      ST_ADDR: begin
        take_bit  = sample_edge;
        last_addr = sample_edge && (cnt == ADDR_END);
        if (last_addr) state_nx = ST_DATA;
      end
      ST_DATA: begin
        take_bit  = sample_edge;
        last_data = sample_edge && (cnt == DATA_END);
        if (last_data) state_nx = ST_DONE;
      end
      default: ;
    endcase
    if (cs_rise) state_nx = ST_IDLE;
  end

  // Shadow capture and frame completion; the visible fields only change
  // when a whole frame has been clocked in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      cmd_sh      <= '0;
      addr_sh     <= '0;
      data_sh     <= '0;
      cmd         <= '0;
      address     <= '0;
      data        <= '0;
      frame_valid <= 1'b0;
      wr_en       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      wr_en       <= 1'b0;
      if (cs_rise || cs_fall) begin
        cnt     <= '0;
        cmd_sh  <= '0;
        addr_sh <= '0;
        data_sh <= '0;
      end else if (take_bit) begin
        cnt <= cnt + CNT_W'(1);
        if (state == ST_CMD)       cmd_sh  <= {cmd_sh[CMD_W-2:0], mosi_s};
        else if (state == ST_ADDR) addr_sh <= {addr_sh[ADDR_W-2:0], mosi_s};
        else                       data_sh <= {data_sh[DATA_W-2:0], mosi_s};
      end
      if (last_data) begin
        cmd         <= cmd_sh;
        address     <= addr_sh;
        data        <= {data_sh[DATA_W-2:0], mosi_s};
        frame_valid <= 1'b1;
        wr_en       <= (cmd_sh == WR_CMD);
      end
    end
  end

  assign miso_oe = ~cs_n_s;

`ifdef SPI_SLAVE_READBACK_EN
  localparam logic [CNT_W-1:0] DATA_START = CNT_W'(CMD_W + ADDR_W);

  logic              rd_req_p0, rd_cap_p1, rd_frame, miso_r;
  logic [DATA_W-1:0] rd_sh;

  // rd_req_p0 -> rd_cap_p1: rd_data is valid the cycle after the request.
  // With CPHA=0 the MSB must be on the wire before the first data sample,
  // so it goes out at capture and the shift edge that precedes the first
  // data sample is skipped. With CPHA=1 the first data shift edge presents
  // the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_req_p0 <= 1'b0;
      rd_cap_p1 <= 1'b0;
      rd_frame  <= 1'b0;
      miso_r    <= 1'b0;
      rd_sh     <= '0;
    end else begin
      rd_req_p0 <= last_addr && (cmd_sh == RD_CMD);
      rd_cap_p1 <= rd_req_p0;
      if (cs_rise || cs_fall) begin
        rd_frame <= 1'b0;
        miso_r   <= 1'b0;
        rd_sh    <= '0;
      end else begin
        if (rd_req_p0) rd_frame <= 1'b1;
        if (rd_cap_p1) begin
          if (CPHA == 1'b0) begin
            miso_r <= rd_data[DATA_W-1];
            rd_sh  <= {rd_data[DATA_W-2:0], 1'b0};
          end else begin
            rd_sh  <= rd_data;
          end
        end else if (shift_edge && rd_frame && state == ST_DATA &&
                     (CPHA == 1'b1 || cnt != DATA_START)) begin
          miso_r <= rd_sh[DATA_W-1];
          rd_sh  <= {rd_sh[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign rd_req = rd_req_p0;
  assign miso   = miso_r & rd_frame & (state == ST_DATA);
`else
  logic unused_rd;
  assign unused_rd = ^{rd_data, shift_edge, RD_CMD};
  assign rd_req    = 1'b0;
  assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame: one instance per SPI mode (index = {CPOL,CPHA}),
// a bit-banged SPI master task, and a scoreboard of expected completed frames.
module tb_spi_slave_frame;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mosi;
  logic [31:0] rd_data;
  logic [3:0]  sck_m, cs_n_m;
  logic [3:0]  miso_m, oe_m, fv_m, wr_m, rd_m;
  logic [7:0]  cmd_m  [4];
  logic [23:0] addr_m [4];
  logic [31:0] data_m [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_frame #(
      .CMD_W      (8),
      .ADDR_W     (24),
      .DATA_W     (32),
      .CPOL       ((g / 2) % 2 == 1),
      .CPHA       (g % 2 == 1),
      .SYNC_STAGES(2),
      .WR_CMD     (8'hB5),
      .RD_CMD     (8'h0B)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sck        (sck_m[g]),
      .cs_n       (cs_n_m[g]),
      .mosi       (mosi),
      .miso       (miso_m[g]),
      .miso_oe    (oe_m[g]),
      .cmd        (cmd_m[g]),
      .address    (addr_m[g]),
      .data       (data_m[g]),
      .frame_valid(fv_m[g]),
      .wr_en      (wr_m[g]),
      .rd_req     (rd_m[g]),
      .rd_data    (rd_data)
    );
  end

  typedef struct {
    int          inst;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [31:0] data;
    logic        wr;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_err  = 0;
  int   rd_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every completed frame must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int m = 0; m < 4; m++) begin
      if (rd_m[m]) rd_cnt++;
      if (fv_m[m]) begin
        if (sb_q.size() == 0) chk("fv_spurious", sb_q.size(), 1);
        else begin
          e = sb_q.pop_front();
          chk("fv_inst", m, e.inst);
          chk("cmd", cmd_m[m], e.cmd);
          chk("address", addr_m[m], e.addr);
          chk("data", data_m[m], e.data);
          chk("wr_en", wr_m[m], e.wr);
        end
      end else if (wr_m[m]) begin
        chk("wr_without_fv", wr_m[m], fv_m[m]);
      end
    end
  end

  // Bit-banged master: bit i goes out as tx[nbits-1-i]; miso is captured
  // just before each slave sample edge. rst_at >= 0 pulses rst_n there.
  task automatic spi_frame(input int mode, input int nbits, input logic [127:0] tx,
                           input int rst_at, output logic [127:0] rx);
    logic cpol, cpha;
    cpol = ((mode / 2) % 2) == 1;
    cpha = (mode % 2) == 1;
    rx   = '0;
    cs_n_m[mode] = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("miso_oe_on", oe_m[mode], 1'b1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_cmd", cmd_m[mode], 8'h00);
        chk("rst_addr", addr_m[mode], 24'h0);
        chk("rst_data", data_m[mode], 32'h0);
        chk("rst_ctrl", {fv_m[mode], wr_m[mode], rd_m[mode], miso_m[mode]}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (!cpha) begin
        mosi = tx[nbits-1-i];
        repeat (HALF) @(negedge clk);
        rx[nbits-1-i] = miso_m[mode];
        sck_m[mode] = ~cpol;
        repeat (HALF) @(negedge clk);
        sck_m[mode] = cpol;
      end else begin
        sck_m[mode] = ~cpol;
        mosi = tx[nbits-1-i];
        repeat (HALF) @(negedge clk);
        rx[nbits-1-i] = miso_m[mode];
        sck_m[mode] = cpol;
        repeat (HALF) @(negedge clk);
      end
    end
    repeat (HALF) @(negedge clk);
    cs_n_m[mode] = 1'b1;
    repeat (8) @(negedge clk);
    chk("miso_oe_off", oe_m[mode], 1'b0);
  endtask

  task automatic run_frame(input int mode, input logic [7:0] c, input logic [23:0] a,
                           input logic [31:0] d, output logic [31:0] rdata);
    exp_t         e;
    logic [127:0] rx;
    e.inst = mode; e.cmd = c; e.addr = a; e.data = d; e.wr = (c == 8'hB5);
    sb_q.push_back(e);
    spi_frame(mode, 64, {64'h0, c, a, d}, -1, rx);
    rdata = rx[31:0];
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  rdv;
    logic [127:0] rx;
    int           rd_before;
    exp_t         e;

    rst_n   = 1'b0;
    mosi    = 1'b0;
    rd_data = 32'h0;
    sck_m   = 4'b1100;
    cs_n_m  = 4'hF;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk("reset_cmd", cmd_m[m], 8'h00);
      chk("reset_addr", addr_m[m], 24'h0);
      chk("reset_data", data_m[m], 32'h0);
      chk("reset_ctrl", {fv_m[m], wr_m[m], rd_m[m], miso_m[m], oe_m[m]}, 5'h0);
    end

    // Same write frame in all four modes.
    for (int m = 0; m < 4; m++) run_frame(m, 8'hB5, 24'h123456, 32'hDEADBEEF, rdv);

    // Abort after 20 bits: nothing completes, previous values held.
    spi_frame(0, 20, {108'h0, 20'hA5C3E}, -1, rx);
    repeat (4) @(negedge clk);
    chk("abort_cmd_hold", cmd_m[0], 8'hB5);
    chk("abort_addr_hold", addr_m[0], 24'h123456);
    chk("abort_data_hold", data_m[0], 32'hDEADBEEF);
    run_frame(0, 8'h5A, 24'hABCDEF, 32'h01234567, rdv);

    // Read frames, one per CPHA setting.
    for (int m = 0; m < 2; m++) begin
      rd_before = rd_cnt;
      rd_data   = 32'hCAFEF00D;
      run_frame(m, 8'h0B, 24'h000010, 32'h13572468, rdv);
      rd_data   = 32'h0;
`ifdef SPI_SLAVE_READBACK_EN
      chk("rd_req_count", rd_cnt - rd_before, 1);
      chk("miso_data", rdv, 32'hCAFEF00D);
`else
      chk("rd_req_count", rd_cnt - rd_before, 0);
      chk("miso_data", rdv, 32'h0);
`endif
    end

    // Overlength: 72 bits, trailing byte must be ignored.
    e.inst = 2; e.cmd = 8'hB5; e.addr = 24'h0F0F0F; e.data = 32'h89ABCDEF; e.wr = 1'b1;
    sb_q.push_back(e);
    spi_frame(2, 72, {56'h0, 8'hB5, 24'h0F0F0F, 32'h89ABCDEF, 8'hFF}, -1, rx);
    chk("overlength_drained", sb_q.size(), 0);

    // Reset in the middle of the data phase, then a clean frame.
    spi_frame(3, 64, {64'h0, 8'hB5, 24'h111111, 32'h22222222}, 40, rx);
    chk("rst_cmd_other", cmd_m[0], 8'h00);
    chk("rst_data_other", data_m[2], 32'h0);
    run_frame(3, 8'hB5, 24'h654321, 32'h0BADF00D, rdv);

    repeat (20) @(negedge clk);
    chk("sb_empty_end", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_slave_frame.md
Name: spi_slave_frame

Overview:
- Parametrised successor to the legacy SCK-clocked SPI command slave.
- Runs entirely on the system clock: SCK/CS/MOSI are synchronised and edge-detected; all four SPI modes (CPOL/CPHA) are supported.
- Field widths are configurable; a completed frame is flagged with a single-cycle strobe; read commands return data on MISO.
- Sits between the external SPI pins and the register/memory fabric.

Parameters:
- CMD_W, 8, command field width in bits.
- ADDR_W, 24, address field width in bits.
- DATA_W, 32, data field width in bits.
- CPOL, 0, SCK idle level.
- CPHA, 0: sample on leading edge; 1: sample on trailing edge.
- SYNC_STAGES, 2, synchroniser depth for sck/cs_n/mosi (min 2).
- WR_CMD, 8'hB5, write command code (CMD_W bits).
- RD_CMD, 8'h0B, read command code (CMD_W bits).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock (async to clk).
- cs_n  in  1  SPI chip select, active low (async).
- mosi  in  1  SPI data in (async).
- miso  out  1  SPI data out.
- miso_oe  out  1  MISO output enable.
- cmd  out  CMD_W  last completed command.
- address  out  ADDR_W  last completed address.
- data  out  DATA_W  last completed write data.
- frame_valid  out  1  one-cycle pulse per completed frame.
- wr_en  out  1  one-cycle pulse; completed frame with cmd==WR_CMD.
- rd_req  out  1  one-cycle pulse; address phase done with cmd==RD_CMD.
- rd_data  in  DATA_W  read data, valid the cycle after rd_req.

Behaviour:
- Reset: cmd/address/data = 0; frame_valid/wr_en/rd_req/miso/miso_oe = 0; synchronisers preset to idle (sck=CPOL, cs_n=1); FSM = IDLE.
- Sample edge: rising when CPOL==CPHA, else falling. Shift edge is the opposite edge. Edges detected on synchronised sck.
- An edge counts only if synchronised cs_n is low in the same cycle. Edges with cs_n high are ignored.
- Supported rate: f_sck <= f_clk/8.
- FSM states: IDLE, CMD, ADDR, DATA, DONE.
  - IDLE -> CMD on cs_n falling.
  - CMD -> ADDR after CMD_W sampled bits.
  - ADDR -> DATA after ADDR_W sampled bits.
  - DATA -> DONE after DATA_W sampled bits.
  - DONE -> IDLE on cs_n rising.
  - Any state -> IDLE on cs_n rising.
- Bit order is MSB first. Bits shift into internal shadow registers; a single bit counter of width $clog2(CMD_W+ADDR_W+DATA_W+1) is used.
- Frame completion: on the cycle after the last data sample, cmd/address/data load from shadow and frame_valid pulses; wr_en pulses in the same cycle if cmd==WR_CMD.
- Outputs hold their values until the next completed frame.
- Abort: cs_n rising before the DATA phase completes -> no pulses, outputs unchanged, shadow registers and counter cleared.
- Overlength: sample edges in DONE are ignored; no second pulse.
- rd_req pulses the cycle after the last address sample, only when the shadow cmd == RD_CMD. rd_data is captured on the following cycle.
- MISO in a read frame:
  - CPHA=0: rd_data MSB drives miso immediately after capture; subsequent bits update on each shift edge.
  - CPHA=1: MSB drives miso on the first shift edge of DATA.
  - Write data from mosi is still shifted in during a read frame.
- miso_oe = ~cs_n (synchronised). miso = 0 outside the read data phase.
- A cs_n low pulse shorter than the synchroniser latency may be missed; this is permitted.

Optional Feature:
- Macro: SPI_SLAVE_READBACK_EN.
- Defined: RD_CMD handling, rd_req, and MISO shifting as described above.
- Undefined: rd_req is tied to 0, miso is tied to 0, rd_data is ignored, and RD_CMD frames complete as ordinary frames (frame_valid only).

Decomposition:
- Shared package spi_pkg:
  - FSM state enum.
  - Default WR_CMD/RD_CMD codes.
  - Mode encoding helper (sample-edge polarity from CPOL/CPHA).
- Sub-module spi_pin_sync: SYNC_STAGES flop synchroniser for sck/cs_n/mosi, plus sample/shift-edge and cs_n fall/rise pulse generation.

Test Plan:
- Mode 0 frame: cmd B5, addr 123456, data DEADBEEF -> one frame_valid + wr_en pulse; outputs 0xB5/0x123456/0xDEADBEEF.
- Repeat the same frame in modes 1, 2 and 3 -> identical outputs; no extra pulses.
- Abort: cs_n rises after 20 bits -> no pulses; outputs keep the previous frame's values; next full frame captured correctly.
- Read: cmd 0B, addr 000010, rd_data=CAFEF00D -> rd_req one cycle after bit 32; miso shifts CAFEF00D MSB first; frame_valid pulses, no wr_en.
- Overlength: 72 bits with cmd B5 -> exactly one frame_valid/wr_en; data equals bits 32..63.
- Reset: rst_n asserted mid-DATA -> all outputs 0 immediately; the next frame after release is captured cleanly.
